// File: rtl/cpu_microsequencer.sv
// Microprogram sequencer: advances the microstate once per machine cycle and
// resolves NEXT/JUMP/COND/DISPATCH/CALL/RETURN branch fields from microcode ROM.
module cpu_microsequencer #(
  parameter int STATE_W       = 8,
  parameter int OPCODE_W      = 8,
  parameter int COND_W        = 4,
  parameter int STACK_DEPTH   = 2,
  parameter int PHASES        = 4,
  parameter int RESET_STATE   = 0,
  parameter int INVALID_STATE = 1,
  parameter int IRQ_STATE     = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             stall,
  input  logic [2:0]                       br_op,
  input  logic [STATE_W-1:0]               br_target,
  input  logic [$clog2(COND_W)-1:0]        cond_sel,
  input  logic                             cond_inv,
  input  logic [COND_W-1:0]                cond_vec,
  input  logic [OPCODE_W-1:0]              opcode,
  input  logic [STATE_W-1:0]               disp_state,
  input  logic                             disp_valid,
  input  logic                             irq_pending,
  output logic [STATE_W-1:0]               state,
  output logic [$clog2(PHASES)-1:0]        phase,
  output logic                             last_phase,
  output logic [$clog2(STACK_DEPTH+1)-1:0] depth,
  output logic                             irq_ack,
  output logic                             err_overflow,
  output logic                             err_underflow
);

  localparam int PHASE_W = $clog2(PHASES);
  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
  localparam int PTR_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  typedef enum logic [2:0] {
    BR_NEXT     = 3'd0,
    BR_JUMP     = 3'd1,
    BR_COND     = 3'd2,
    BR_DISPATCH = 3'd3,
    BR_CALL     = 3'd4,
    BR_RETURN   = 3'd5
  } br_op_e;

  logic [STATE_W-1:0] stack_mem [2**PTR_W];
  logic [STATE_W-1:0] state_inc;
  logic [STATE_W-1:0] state_nxt;
  logic [PTR_W-1:0]   push_idx;
  logic [PTR_W-1:0]   pop_idx;
  logic               step;
  logic               cond_bit;
  logic               stack_full;
  logic               stack_empty;
  logic               do_push;
  logic               do_pop;
  logic               set_ovf;
  logic               set_unf;
  logic               irq_entry;
  logic               unused_opcode;

  // The dispatch target arrives pre-decoded on disp_state; opcode is only observed externally.
  assign unused_opcode = ^opcode;

  assign last_phase  = (phase == PHASE_W'(PHASES - 1));
  assign step        = last_phase && !stall;
  assign state_inc   = state + STATE_W'(1);
  assign stack_full  = (depth == DEPTH_W'(STACK_DEPTH));
  assign stack_empty = (depth == '0);
  assign push_idx    = PTR_W'(depth);
  assign pop_idx     = PTR_W'(depth - DEPTH_W'(1));
  assign cond_bit    = (int'(cond_sel) < COND_W) ? cond_vec[cond_sel] : 1'b0;

  always_comb begin
    state_nxt = state_inc;
    do_push   = 1'b0;
    do_pop    = 1'b0;
    set_ovf   = 1'b0;
    set_unf   = 1'b0;
    irq_entry = 1'b0;
    case (br_op_e'(br_op))
      BR_JUMP: state_nxt = br_target;
      BR_COND: begin
        if (cond_bit ^ cond_inv) state_nxt = br_target;
      end
      BR_DISPATCH: begin
        if (irq_pending) begin
          state_nxt = STATE_W'(IRQ_STATE);
          irq_entry = 1'b1;
        end else if (disp_valid) begin
          state_nxt = disp_state;
        end else begin
          state_nxt = STATE_W'(INVALID_STATE);
        end
      end
      BR_CALL: begin
        state_nxt = br_target;
        if (stack_full) set_ovf = 1'b1;
        else            do_push = 1'b1;
      end
      BR_RETURN: begin
        if (stack_empty) begin
          state_nxt = STATE_W'(INVALID_STATE);
          set_unf   = 1'b1;
        end else begin
          state_nxt = stack_mem[pop_idx];
          do_pop    = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= STATE_W'(RESET_STATE);
      phase         <= '0;
      depth         <= '0;
      irq_ack       <= 1'b0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      irq_ack <= 1'b0;
      if (!last_phase) begin
        phase <= phase + PHASE_W'(1);
      end else if (!stall) begin
        phase         <= '0;
        state         <= state_nxt;
        irq_ack       <= irq_entry;
        err_overflow  <= err_overflow | set_ovf;
        err_underflow <= err_underflow | set_unf;
        if (do_push)     depth <= depth + DEPTH_W'(1);
        else if (do_pop) depth <= depth - DEPTH_W'(1);
      end
    end
  end

  // Stack contents need no reset: depth=0 makes every stale entry unreachable.
  always_ff @(posedge clk) begin
    if (!reset && step && do_push) stack_mem[push_idx] <= state_inc;
  end

endmodule

// File: tb/tb_cpu_microsequencer.sv
// Directed bench for cpu_microsequencer: a cycle model checked on every falling
// edge, plus literal expectations for each scenario of interest.
module tb_cpu_microsequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       stall = 1'b0;
  logic [2:0] br_op = 3'd0;
  logic [7:0] br_target = 8'h00;
  logic [1:0] cond_sel = 2'd0;
  logic       cond_inv = 1'b0;
  logic [3:0] cond_vec = 4'h0;
  logic [7:0] opcode = 8'h00;
  logic [7:0] disp_state = 8'h00;
  logic       disp_valid = 1'b0;
  logic       irq_pending = 1'b0;
  logic [7:0] state;
  logic [1:0] phase;
  logic       last_phase;
  logic [1:0] depth;
  logic       irq_ack;
  logic       err_overflow;
  logic       err_underflow;

  int total = 0;
  int bad = 0;
  bit started = 1'b0;

  cpu_microsequencer #(
    .STATE_W(8), .OPCODE_W(8), .COND_W(4), .STACK_DEPTH(2), .PHASES(4),
    .RESET_STATE(0), .INVALID_STATE(1), .IRQ_STATE(2)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall), .br_op(br_op), .br_target(br_target),
    .cond_sel(cond_sel), .cond_inv(cond_inv), .cond_vec(cond_vec), .opcode(opcode),
    .disp_state(disp_state), .disp_valid(disp_valid), .irq_pending(irq_pending),
    .state(state), .phase(phase), .last_phase(last_phase), .depth(depth),
    .irq_ack(irq_ack), .err_overflow(err_overflow), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  // Reference model: integers and a plain array stack, 4 clocks per machine cycle.
  int m_state = 0, m_phase = 0, m_depth = 0;
  int m_stk [2];
  bit m_ack = 0, m_ovf = 0, m_unf = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_state <= 0; m_phase <= 0; m_depth <= 0;
      m_ack <= 0; m_ovf <= 0; m_unf <= 0;
    end else begin
      m_ack <= 0;
      if (m_phase < 3) begin
        m_phase <= m_phase + 1;
      end else if (!stall) begin
        m_phase <= 0;
        case (br_op)
          3'd1: m_state <= br_target;
          3'd2: m_state <= (cond_vec[cond_sel] ^ cond_inv) ? int'(br_target) : (m_state + 1) % 256;
          3'd3: begin
            if (irq_pending) begin m_state <= 2; m_ack <= 1; end
            else m_state <= disp_valid ? int'(disp_state) : 1;
          end
          3'd4: begin
            m_state <= br_target;
            if (m_depth == 2) m_ovf <= 1;
            else begin m_stk[m_depth] <= (m_state + 1) % 256; m_depth <= m_depth + 1; end
          end
          3'd5: begin
            if (m_depth == 0) begin m_state <= 1; m_unf <= 1; end
            else begin m_state <= m_stk[m_depth - 1]; m_depth <= m_depth - 1; end
          end
          default: m_state <= (m_state + 1) % 256;
        endcase
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("model.state", int'(state), m_state);
      chk("model.phase", int'(phase), m_phase);
      chk("model.last_phase", int'(last_phase), int'(m_phase == 3));
      chk("model.depth", int'(depth), m_depth);
      chk("model.irq_ack", int'(irq_ack), int'(m_ack));
      chk("model.err_overflow", int'(err_overflow), int'(m_ovf));
      chk("model.err_underflow", int'(err_underflow), int'(m_unf));
    end
  end

  // Drive one machine cycle's branch fields; returns at the falling edge after the step.
  task automatic mc(input int op, input int tgt);
    br_op = 3'(op);
    br_target = 8'(tgt);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    started = 1'b1;
    chk("reset.state", int'(state), 0);
    chk("reset.phase", int'(phase), 0);
    chk("reset.depth", int'(depth), 0);
    chk("reset.last_phase", int'(last_phase), 0);
    reset = 1'b0;

    mc(0, 0); chk("next.1", int'(state), 8'h01);
    mc(0, 0); chk("next.2", int'(state), 8'h02);
    mc(0, 0); chk("next.3", int'(state), 8'h03);
    mc(1, 8'hFF); chk("jump.ff", int'(state), 8'hFF);
    mc(0, 0); chk("next.wrap", int'(state), 8'h00);

    cond_vec = 4'b0100; cond_sel = 2'd2; cond_inv = 1'b0;
    mc(2, 8'h40); chk("cond.taken", int'(state), 8'h40);
    cond_inv = 1'b1;
    mc(2, 8'h70); chk("cond.inv", int'(state), 8'h41);
    cond_inv = 1'b0; cond_sel = 2'd1;
    mc(2, 8'h70); chk("cond.clear_bit", int'(state), 8'h42);

    opcode = 8'hCB; disp_state = 8'h80; disp_valid = 1'b1;
    mc(3, 0); chk("disp.hit", int'(state), 8'h80);
    disp_valid = 1'b0;
    mc(3, 0); chk("disp.miss", int'(state), 8'h01);
    irq_pending = 1'b1; disp_valid = 1'b1;
    mc(3, 0); chk("disp.irq", int'(state), 8'h02);
    chk("irq_ack.high", int'(irq_ack), 1);
    irq_pending = 1'b0;
    @(negedge clk); chk("irq_ack.low", int'(irq_ack), 0);
    repeat (3) @(negedge clk);

    mc(1, 8'h05);
    mc(4, 8'h10); chk("call1.state", int'(state), 8'h10); chk("call1.depth", int'(depth), 1);
    mc(1, 8'h12);
    mc(4, 8'h20); chk("call2.state", int'(state), 8'h20); chk("call2.depth", int'(depth), 2);
    mc(5, 0); chk("ret1.state", int'(state), 8'h13); chk("ret1.depth", int'(depth), 1);
    mc(5, 0); chk("ret2.state", int'(state), 8'h06); chk("ret2.depth", int'(depth), 0);
    mc(4, 8'h10);
    mc(4, 8'h20);
    mc(4, 8'h30); chk("ovf.state", int'(state), 8'h30); chk("ovf.depth", int'(depth), 2);
    chk("ovf.flag", int'(err_overflow), 1);
    mc(5, 0); chk("ret3.state", int'(state), 8'h11);
    mc(5, 0); chk("ret4.state", int'(state), 8'h07);
    mc(5, 0); chk("unf.state", int'(state), 8'h01);
    chk("unf.flag", int'(err_underflow), 1);
    chk("ovf.sticky", int'(err_overflow), 1);
    mc(0, 0); chk("unf.sticky", int'(err_underflow), 1);

    // Stall at phase 3 for five clocks, starting from state 2.
    br_op = 3'd0;
    repeat (3) @(negedge clk);
    chk("stall.at_phase3", int'(phase), 3);
    stall = 1'b1;
    repeat (5) @(negedge clk);
    chk("stall.phase", int'(phase), 3);
    chk("stall.state", int'(state), 8'h02);
    stall = 1'b0;
    @(negedge clk);
    chk("release.phase", int'(phase), 0);
    chk("release.state", int'(state), 8'h03);

    repeat (3) @(negedge clk);
    stall = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_stall.state", int'(state), 0);
    chk("rst_stall.phase", int'(phase), 0);
    chk("rst_stall.depth", int'(depth), 0);
    chk("rst_stall.ovf", int'(err_overflow), 0);
    chk("rst_stall.unf", int'(err_underflow), 0);
    reset = 1'b0; stall = 1'b0;
    mc(0, 0); chk("post_reset.next", int'(state), 8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1);
  end

endmodule
